sprite_compositor: RTL and testbench
====================================

SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

Interface
REQ-001 SHALL have parameter NUM_SPRITES, default 4: sprite channel count, 1..8.
REQ-002 SHALL have parameter SCREEN_WIDTH, default 640: active pixels per line.
REQ-003 SHALL have parameter SCREEN_HEIGHT, default 480: active lines per frame.
REQ-004 SHALL have parameter CIDX_W, default 6: colour-index width.
REQ-005 SHALL have parameter SADDR_W, default 15: per-sprite pixelmap address width.
REQ-006 SHALL have ports (clock and reset first):
- iClock  in  1  clock.
- iReset  in  1  reset; synchronous, active-high.
- iFrameStart  in  1  marks pixel (0,0); valid only together with iPixelValid.
- iPixelValid  in  1  one raster pixel this cycle, in raster order.
- iAttrWrEn  in  1  attribute write strobe.
- iAttrIdx  in  3  sprite to write.
- iAttrX, iAttrY  in  12 each  signed top-left position.
- iAttrW, iAttrH  in  10 each  unsigned size.
- iAttrEn  in  1  sprite visible.
- oSprAddr  out  NUM_SPRITES*SADDR_W  packed pixelmap addresses; sprite i at [i*SADDR_W +: SADDR_W].
- iSprCidx  in  NUM_SPRITES*CIDX_W  pixelmap data, returned one cycle after oSprAddr.
- iBgCidx  in  CIDX_W  background index, aligned with iSprCidx.
- oCidx  out  CIDX_W  composited colour index.
- oValid  out  1  oCidx valid.
- oCollision  out  1  previous frame had a sprite-0 overlap.

Function
REQ-007 SHALL keep an internal x/y raster counter. iFrameStart&iPixelValid loads x=0,y=0. Each other iPixelValid advances x. x wraps at SCREEN_WIDTH-1 to 0 with y+1. y saturates at SCREEN_HEIGHT-1 until the next iFrameStart.
REQ-008 SHALL hold pending attributes per sprite, written on iAttrWrEn. Writes with iAttrIdx>=NUM_SPRITES are ignored.
REQ-009 SHALL copy all pending attributes into active shadow registers on the cycle iFrameStart&iPixelValid. Compositing uses only shadow values.
REQ-010 SHALL let a write coinciding with the frame-start copy land in pending only, taking effect next frame.
REQ-011 Stage 1 (registered) SHALL compute per sprite hit = En & x>=X & x<X+W & y>=Y & y<Y+H. Compares are signed, at least 13 bits wide, with no overflow.
REQ-012 Stage 1 SHALL drive oSprAddr[i] = (x-X)+(y-Y)*W truncated to SADDR_W on hit, else 0.
REQ-013 Stage 2 SHALL register iSprCidx and iBgCidx with the delayed hit vector.
REQ-014 Stage 3 SHALL register oCidx as the lowest-index sprite with hit and nonzero cidx, else iBgCidx. Colour index 0 is transparent.
REQ-015 SHALL assert oValid exactly 3 cycles after each iPixelValid: fixed latency, full throughput, no stalls.
REQ-016 SHALL set an internal sticky flag when sprite 0 and any other sprite both hit with nonzero cidx on the same pixel.
REQ-017 At frame start SHALL transfer the sticky flag to oCollision and clear it. A hit in that same frame-start pixel counts toward the new frame.
REQ-018 SHALL produce no output for cycles with iPixelValid low; pipeline bubbles propagate with oValid low.
REQ-019 SHALL give width or height 0 no hit. A sprite fully off-screen (negative X, X+W<=0) SHALL give no hit.

Reset
REQ-020 On iReset SHALL clear x, y, all pending and shadow attributes (En=0), pipeline valids, sticky flag, oCollision, oCidx, oValid and oSprAddr to 0.
REQ-021 Reset mid-frame SHALL discard in-flight pixels: oValid=0 the next cycle. Output resumes 3 cycles after the next accepted pixel.
REQ-022 After reset, with no attributes written, oCidx SHALL equal the delayed iBgCidx.

Verification
REQ-023 Write sprite1 X=100,Y=50,W=34,H=24,En, then frame start. At pixel (100,50): oSprAddr[1]=0. At (133,73): 815. At (134,50): 0 and no hit.
REQ-024 Sprites 0 and 2 overlap at a pixel, cidx 5 and 9 -> oCidx=5. Sprite0 cidx 0 -> oCidx=9. Both 0 -> oCidx=iBgCidx.
REQ-025 Attribute write mid-frame -> no change until the next iFrameStart. Write on the frame-start cycle -> applies the frame after.
REQ-026 Sprite0/1 nonzero overlap in frame N -> oCollision=1 from frame N+1 start through frame N+2 start. No overlap in N+1 -> oCollision=0 after.
REQ-027 Sprite X=-20,W=52 -> hits x=0..31 with oSprAddr starting at 20. X=-52 -> never hit.
REQ-028 iPixelValid toggling 1,0,1 -> oValid 1,0,1 delayed 3 cycles. iReset pulsed mid-stream -> oValid=0 next cycle.

Source files
------------

// File: rtl/sprite_compositor.sv
// Sprite compositor: tracks the raster position, hit-tests every sprite against it,
// issues pixelmap addresses and merges the returned colour indices over the background.
module sprite_compositor #(
  parameter int NUM_SPRITES   = 4,
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int CIDX_W        = 6,
  parameter int SADDR_W       = 15
) (
  input  logic                           iClock,
  input  logic                           iReset,
  input  logic                           iFrameStart,
  input  logic                           iPixelValid,
  input  logic                           iAttrWrEn,
  input  logic [2:0]                     iAttrIdx,
  input  logic [11:0]                    iAttrX,
  input  logic [11:0]                    iAttrY,
  input  logic [9:0]                     iAttrW,
  input  logic [9:0]                     iAttrH,
  input  logic                           iAttrEn,
  output logic [NUM_SPRITES*SADDR_W-1:0] oSprAddr,
  input  logic [NUM_SPRITES*CIDX_W-1:0]  iSprCidx,
  input  logic [CIDX_W-1:0]              iBgCidx,
  output logic [CIDX_W-1:0]              oCidx,
  output logic                           oValid,
  output logic                           oCollision
);

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [9:0]  w;
    logic [9:0]  h;
    logic        en;
  } attr_t;

  localparam logic [11:0] LastX = 12'(SCREEN_WIDTH - 1);
  localparam logic [11:0] LastY = 12'(SCREEN_HEIGHT - 1);

  // Signed 14-bit span test: start is sign-extended so off-screen sprites never wrap into view.
  function automatic logic spanHit(input logic [11:0] pos, input logic [11:0] start,
                                   input logic [9:0] len);
    logic signed [13:0] p;
    logic signed [13:0] s;
    logic signed [13:0] e;
    p = signed'({2'b00, pos});
    s = signed'({{2{start[11]}}, start});
    e = s + signed'({4'b0000, len});
    return (p >= s) && (p < e);
  endfunction

  function automatic logic [SADDR_W-1:0] pixAddr(input logic [11:0] px, input logic [11:0] py,
                                                 input attr_t a);
    logic [31:0] relX;
    logic [31:0] relY;
    relX = {20'd0, px} - {{20{a.x[11]}}, a.x};
    relY = {20'd0, py} - {{20{a.y[11]}}, a.y};
    return SADDR_W'(relX + relY * {22'd0, a.w});
  endfunction

  logic                           frameStart;
  logic [11:0]                    rasterX_q, rasterX_d, rasterY_q, rasterY_d;
  logic [11:0]                    pixX, pixY;
  attr_t                          pend_q   [NUM_SPRITES];
  attr_t                          shadow_q [NUM_SPRITES];
  attr_t                          active;
  logic [NUM_SPRITES-1:0]         hit_d, hit1_q, hit2_q;
  logic [NUM_SPRITES*SADDR_W-1:0] sprAddr_d, sprAddr_q;
  logic                           valid1_q, valid2_q, valid3_q;
  logic                           fs1_q, fs2_q;
  logic [NUM_SPRITES*CIDX_W-1:0]  cidx2_q;
  logic [CIDX_W-1:0]              bg2_q, pick_d, cidx3_q;
  logic [NUM_SPRITES-1:0]         opaque;
  logic                           found, others, collNow;
  logic                           sticky_q, collision_q;

  assign frameStart = iFrameStart & iPixelValid;

  always_comb begin
    pixX      = frameStart ? 12'd0 : rasterX_q;
    pixY      = frameStart ? 12'd0 : rasterY_q;
    rasterX_d = rasterX_q;
    rasterY_d = rasterY_q;
    if (iPixelValid) begin
      if (pixX == LastX) begin
        rasterX_d = 12'd0;
        rasterY_d = (pixY == LastY) ? pixY : pixY + 12'd1;
      end else begin
        rasterX_d = pixX + 12'd1;
        rasterY_d = pixY;
      end
    end
  end

  // The frame-start copy samples pending before any write landing in the same cycle.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        pend_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (frameStart) shadow_q[i] <= pend_q[i];
        if (iAttrWrEn && iAttrIdx == 3'(i))
          pend_q[i] <= '{x: iAttrX, y: iAttrY, w: iAttrW, h: iAttrH, en: iAttrEn};
      end
    end
  end

  // The frame-start pixel already belongs to the new frame, so it sees the freshly copied set.
  always_comb begin
    hit_d     = '0;
    sprAddr_d = '0;
    active    = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      active = frameStart ? pend_q[i] : shadow_q[i];
      if (iPixelValid && active.en && spanHit(pixX, active.x, active.w) &&
          spanHit(pixY, active.y, active.h)) begin
        hit_d[i] = 1'b1;
        sprAddr_d[i*SADDR_W +: SADDR_W] = pixAddr(pixX, pixY, active);
      end
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      rasterX_q <= '0;
      rasterY_q <= '0;
      valid1_q  <= 1'b0;
      fs1_q     <= 1'b0;
      hit1_q    <= '0;
      sprAddr_q <= '0;
      valid2_q  <= 1'b0;
      fs2_q     <= 1'b0;
      hit2_q    <= '0;
      cidx2_q   <= '0;
      bg2_q     <= '0;
    end else begin
      rasterX_q <= rasterX_d;
      rasterY_q <= rasterY_d;
      valid1_q  <= iPixelValid;
      fs1_q     <= frameStart;
      hit1_q    <= hit_d;
      sprAddr_q <= sprAddr_d;
      valid2_q  <= valid1_q;
      fs2_q     <= fs1_q;
      hit2_q    <= hit1_q;
      cidx2_q   <= iSprCidx;
      bg2_q     <= iBgCidx;
    end
  end

  always_comb begin
    opaque = '0;
    pick_d = bg2_q;
    found  = 1'b0;
    others = 1'b0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      opaque[i] = hit2_q[i] && (cidx2_q[i*CIDX_W +: CIDX_W] != '0);
      if (opaque[i] && !found) begin
        pick_d = cidx2_q[i*CIDX_W +: CIDX_W];
        found  = 1'b1;
      end
      if (i > 0 && opaque[i]) others = 1'b1;
    end
    collNow = opaque[0] & others;
  end

  // Collision bookkeeping follows the pixel stream, so frame boundaries line up with output pixels.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      valid3_q    <= 1'b0;
      cidx3_q     <= '0;
      sticky_q    <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      valid3_q <= valid2_q;
      if (valid2_q) begin
        cidx3_q <= pick_d;
        if (fs2_q) begin
          collision_q <= sticky_q;
          sticky_q    <= collNow;
        end else begin
          sticky_q <= sticky_q | collNow;
        end
      end
    end
  end

  assign oSprAddr   = sprAddr_q;
  assign oCidx      = cidx3_q;
  assign oValid     = valid3_q;
  assign oCollision = collision_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Randomised scoreboard bench for sprite_compositor with a behavioural raster/sprite model
// and a pixelmap memory that answers oSprAddr in the cycle it is presented.
module tb_sprite_compositor;

  localparam int NS    = 4;
  localparam int SCR_W = 160;
  localparam int SCR_H = 80;
  localparam int CW    = 6;
  localparam int SW    = 15;

  typedef struct {
    int x;
    int y;
    int w;
    int h;
    bit en;
  } attrS;

  typedef struct {
    int         due;
    logic [5:0] cidx;
    bit         coll;
  } sbEntry;

  typedef struct {
    int                 due;
    logic [NS*SW-1:0]   addr;
  } addrEntry;

  logic              iClock = 1'b0;
  logic              iReset = 1'b1;
  logic              iFrameStart = 1'b0;
  logic              iPixelValid = 1'b0;
  logic              iAttrWrEn = 1'b0;
  logic [2:0]        iAttrIdx = '0;
  logic [11:0]       iAttrX = '0;
  logic [11:0]       iAttrY = '0;
  logic [9:0]        iAttrW = '0;
  logic [9:0]        iAttrH = '0;
  logic              iAttrEn = 1'b0;
  logic [NS*SW-1:0]  oSprAddr;
  logic [NS*CW-1:0]  iSprCidx;
  logic [CW-1:0]     iBgCidx;
  logic [CW-1:0]     oCidx;
  logic              oValid;
  logic              oCollision;

  logic [5:0]        spriteMem [NS][256];
  logic [5:0]        bgNext = '0;
  logic [5:0]        bgReg = '0;
  int                cycleCount = 0;
  int                vectors = 0;
  int                miscompares = 0;

  sbEntry            sbQ[$];
  addrEntry          addrQ[$];
  attrS              pendA [NS];
  attrS              shadA [NS];
  int                rx = 0;
  int                ry = 0;
  bit                frameColl = 0;
  bit                collOut = 0;
  bit                wrPend = 0;
  int                wrIdx = 0;
  attrS              wrA;

  sprite_compositor #(
    .NUM_SPRITES(NS), .SCREEN_WIDTH(SCR_W), .SCREEN_HEIGHT(SCR_H),
    .CIDX_W(CW), .SADDR_W(SW)
  ) dut (
    .iClock(iClock), .iReset(iReset), .iFrameStart(iFrameStart), .iPixelValid(iPixelValid),
    .iAttrWrEn(iAttrWrEn), .iAttrIdx(iAttrIdx), .iAttrX(iAttrX), .iAttrY(iAttrY),
    .iAttrW(iAttrW), .iAttrH(iAttrH), .iAttrEn(iAttrEn), .oSprAddr(oSprAddr),
    .iSprCidx(iSprCidx), .iBgCidx(iBgCidx), .oCidx(oCidx), .oValid(oValid),
    .oCollision(oCollision)
  );

  always #5 iClock = ~iClock;

  always @(posedge iClock) begin
    cycleCount <= cycleCount + 1;
    bgReg      <= bgNext;
  end

  assign iBgCidx = bgReg;

  always_comb begin
    for (int i = 0; i < NS; i++) iSprCidx[i*CW +: CW] = spriteMem[i][oSprAddr[i*SW +: 8]];
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cycleCount, act, exp);
    end
  endtask

  // Reference: a pixel is a plain rectangle test per sprite, lowest index with a visible colour wins.
  function automatic void evalPixel(input int px, input int py, input logic [5:0] bg,
                                    output logic [5:0] cidx, output bit coll,
                                    output logic [NS*SW-1:0] addrVec);
    bit         opaque [NS];
    bit         done;
    int         addr;
    logic [5:0] c;
    cidx    = bg;
    coll    = 0;
    addrVec = '0;
    done    = 0;
    for (int i = 0; i < NS; i++) begin
      opaque[i] = 0;
      if (shadA[i].en && px >= shadA[i].x && px < shadA[i].x + shadA[i].w &&
          py >= shadA[i].y && py < shadA[i].y + shadA[i].h) begin
        addr = ((px - shadA[i].x) + (py - shadA[i].y) * shadA[i].w) % 32768;
        addrVec[i*SW +: SW] = SW'(addr);
        c = spriteMem[i][addr % 256];
        opaque[i] = (c != 0);
        if (opaque[i] && !done) begin
          cidx = c;
          done = 1;
        end
      end
    end
    for (int j = 1; j < NS; j++) if (opaque[0] && opaque[j]) coll = 1;
  endfunction

  task automatic queueWrite(input int idx, input int x, input int y, input int w, input int h,
                            input bit en);
    wrPend = 1;
    wrIdx  = idx;
    wrA.x  = x;
    wrA.y  = y;
    wrA.w  = w;
    wrA.h  = h;
    wrA.en = en;
  endtask

  task automatic applyStimulus(input bit pv, input bit fs);
    logic [5:0]       bg;
    logic [5:0]       expC;
    bit               expColl;
    logic [NS*SW-1:0] expAddr;
    sbEntry           se;
    addrEntry         ae;
    @(negedge iClock);
    bg          = 6'($urandom);
    iPixelValid = pv;
    iFrameStart = fs;
    bgNext      = bg;
    iAttrWrEn   = wrPend;
    iAttrIdx    = 3'(wrIdx);
    iAttrX      = 12'(wrA.x);
    iAttrY      = 12'(wrA.y);
    iAttrW      = 10'(wrA.w);
    iAttrH      = 10'(wrA.h);
    iAttrEn     = wrA.en;
    if (pv) begin
      if (fs) begin
        for (int i = 0; i < NS; i++) shadA[i] = pendA[i];
        rx = 0;
        ry = 0;
      end
      evalPixel(rx, ry, bg, expC, expColl, expAddr);
      if (fs) begin
        collOut   = frameColl;
        frameColl = expColl;
      end else begin
        frameColl = frameColl | expColl;
      end
      se.due  = cycleCount + 3;
      se.cidx = expC;
      se.coll = collOut;
      sbQ.push_back(se);
      ae.due  = cycleCount + 1;
      ae.addr = expAddr;
      addrQ.push_back(ae);
      if (rx == SCR_W - 1) begin
        rx = 0;
        if (ry < SCR_H - 1) ry++;
      end else begin
        rx++;
      end
    end
    if (wrPend && wrIdx < NS) pendA[wrIdx] = wrA;
    wrPend = 0;
  endtask

  task automatic runPixels(input int n, input int bubblePct);
    for (int p = 0; p < n; p++) applyStimulus($urandom_range(99) >= bubblePct, 1'b0);
  endtask

  task automatic randomWrite();
    queueWrite($urandom_range(7), int'($urandom_range(190)) - 40, int'($urandom_range(8)) - 5,
               $urandom_range(60), $urandom_range(6), $urandom_range(3) != 0);
  endtask

  task automatic doReset(input int cycles);
    @(negedge iClock);
    iReset      = 1'b1;
    iPixelValid = 1'b0;
    iFrameStart = 1'b0;
    iAttrWrEn   = 1'b0;
    wrPend      = 0;
    sbQ.delete();
    addrQ.delete();
    for (int i = 0; i < NS; i++) begin
      pendA[i] = '{0, 0, 0, 0, 0};
      shadA[i] = '{0, 0, 0, 0, 0};
    end
    rx        = 0;
    ry        = 0;
    frameColl = 0;
    collOut   = 0;
    @(posedge iClock);
    #1;
    checkOutput("resetValid", 64'(oValid), 64'd0);
    checkOutput("resetCidx", 64'(oCidx), 64'd0);
    checkOutput("resetCollision", 64'(oCollision), 64'd0);
    checkOutput("resetSprAddr", 64'(oSprAddr), 64'd0);
    repeat (cycles - 1) @(posedge iClock);
    @(negedge iClock);
    iReset = 1'b0;
  endtask

  always begin : monitor
    sbEntry   se;
    addrEntry ae;
    @(posedge iClock);
    #1;
    if (addrQ.size() > 0 && addrQ[0].due == cycleCount) begin
      ae = addrQ.pop_front();
      checkOutput("sprAddr", 64'(oSprAddr), 64'(ae.addr));
    end
    if (oValid) begin
      if (sbQ.size() == 0 || sbQ[0].due != cycleCount) begin
        checkOutput("unexpectedValid", 64'(oValid), 64'd0);
      end else begin
        se = sbQ.pop_front();
        checkOutput("cidx", 64'(oCidx), 64'(se.cidx));
        checkOutput("collision", 64'(oCollision), 64'(se.coll));
      end
    end else if (sbQ.size() > 0 && sbQ[0].due == cycleCount) begin
      se = sbQ.pop_front();
      checkOutput("missingValid", 64'(oValid), 64'd1);
    end
  end

  initial begin : watchdog
    #600000;
    $display("[TB] FAIL watchdog: simulation did not complete, vectors %0d", vectors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int len;
    wrA = '{0, 0, 0, 0, 0};
    for (int i = 0; i < NS; i++) begin
      pendA[i] = '{0, 0, 0, 0, 0};
      shadA[i] = '{0, 0, 0, 0, 0};
      for (int a = 0; a < 256; a++)
        spriteMem[i][a] = ($urandom_range(3) == 0) ? 6'd0 : 6'($urandom_range(63, 1));
    end
    // Overlap colours for priority/transparency and for the sprite-0 collision frames.
    spriteMem[0][0] = 6'd5;  spriteMem[2][0] = 6'd9;
    spriteMem[0][1] = 6'd0;  spriteMem[2][1] = 6'd9;
    spriteMem[0][2] = 6'd0;  spriteMem[2][2] = 6'd0;
    for (int a = 0; a < 4; a++) begin
      spriteMem[0][a+4] = 6'(a + 20);
      spriteMem[1][a]   = 6'(a + 40);
    end

    doReset(3);
    $display("[TB] background-only stream after reset");
    runPixels(30, 30);

    $display("[TB] directed sprites, long frame with y saturation");
    queueWrite(1, 100, 50, 34, 24, 1); applyStimulus(0, 0);
    queueWrite(0, 10, 0, 4, 1, 1);     applyStimulus(0, 0);
    queueWrite(2, 10, 0, 4, 1, 1);     applyStimulus(0, 0);
    queueWrite(3, -20, 5, 52, 2, 1);   applyStimulus(0, 0);
    queueWrite(5, 0, 0, 200, 100, 1);  applyStimulus(0, 0);
    applyStimulus(1, 1);
    runPixels(12999, 0);

    $display("[TB] mid-frame and frame-start writes, collision frames");
    queueWrite(3, -52, 0, 52, 2, 1);   applyStimulus(1, 0);
    queueWrite(0, 0, 0, 8, 1, 1);      applyStimulus(1, 0);
    queueWrite(1, 4, 0, 8, 1, 1);      applyStimulus(1, 0);
    queueWrite(2, 0, 0, 0, 0, 0);      applyStimulus(1, 0);
    runPixels(40, 10);
    applyStimulus(1, 1);
    runPixels(30, 10);
    queueWrite(1, 4, 0, 8, 1, 0);      applyStimulus(1, 0);
    runPixels(30, 10);
    queueWrite(1, 4, 0, 8, 1, 1);      applyStimulus(1, 1);
    runPixels(60, 10);
    applyStimulus(1, 1);
    runPixels(60, 10);
    applyStimulus(1, 1);
    runPixels(60, 10);

    $display("[TB] randomised frames");
    for (int f = 0; f < 24; f++) begin
      applyStimulus(1, 1);
      len = $urandom_range(400, 50);
      for (int p = 0; p < len; p++) begin
        if (f == 12 && p == len / 2) doReset(2);
        if ($urandom_range(9) == 0) randomWrite();
        applyStimulus($urandom_range(4) != 0, $urandom_range(49) == 0);
      end
    end

    repeat (8) applyStimulus(0, 0);
    if (sbQ.size() != 0) checkOutput("drain", 64'(sbQ.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
